// File: rtl/jkff_pkg.sv
// Shared JK flip-flop definitions: operation encoding, reset value and the next-state rule.
// Used by jk_bit_cell and by the optional toggle counter (JKFF_TOGGLE_CNT_EN) in jk_flip_flop.
package jkff_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_t;

   localparam logic JKFF_RESET_VAL = 1'b0;

   // Next value of one JK bit given its {j,k} operation and current state.
   function automatic logic jk_next(input logic j, input logic k, input logic q);
      jk_op_t op;
      logic   nq;
      op = jk_op_t'({j, k});
      case (op)
         JK_HOLD:   nq = q;
         JK_RESET:  nq = 1'b0;
         JK_SET:    nq = 1'b1;
         JK_TOGGLE: nq = ~q;
         default:   nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// One JK bit: combinational next-state from the shared rule plus a register with
// synchronous active-high reset that takes priority over j/k.
module jk_bit_cell
   import jkff_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_nxt;

   always_comb begin
      q_nxt = jk_next(j, k, q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= JKFF_RESET_VAL;
      end else begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops with complement output.
// Define JKFF_TOGGLE_CNT_EN to add a saturating toggle_cnt of edges on which q changed.
module jk_flip_flop
   import jkff_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q,
`ifdef JKFF_TOGGLE_CNT_EN
   output logic [WIDTH-1:0] q_n,
   output logic [CNT_W-1:0] toggle_cnt
`else
   output logic [WIDTH-1:0] q_n
`endif
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_bit_cell u_cell (
         .clk   (clk),
         .reset (reset),
         .j     (j[i]),
         .k     (k[i]),
         .q     (q[i])
      );
   end

   assign q_n = ~q;

`ifdef JKFF_TOGGLE_CNT_EN
   logic [WIDTH-1:0] q_nxt;
   logic             changing;

   // Recomputes the cells' next state so the counter sees the change on the same edge.
   always_comb begin
      q_nxt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         q_nxt[i] = jk_next(j[i], k[i], q[i]);
      end
   end

   assign changing = (q_nxt != q);

   always_ff @(posedge clk) begin
      if (reset) begin
         toggle_cnt <= '0;
      end else if (changing && (toggle_cnt != {CNT_W{1'b1}})) begin
         toggle_cnt <= toggle_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed bench for jk_flip_flop: a WIDTH=1 instance (CNT_W=2) and a WIDTH=4 instance.
// Counter checks are compiled only when JKFF_TOGGLE_CNT_EN is defined.
module tb_jk_flip_flop;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       j1 = 1'b0, k1 = 1'b0;
   logic [3:0] j4 = '0, k4 = '0;
   logic       q1, qn1;
   logic [3:0] q4, qn4;
`ifdef JKFF_TOGGLE_CNT_EN
   logic [1:0] cnt1;
   logic [7:0] cnt4;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   jk_flip_flop #(.WIDTH(1), .CNT_W(2)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .j          (j1),
      .k          (k1),
      .q          (q1),
`ifdef JKFF_TOGGLE_CNT_EN
      .q_n        (qn1),
      .toggle_cnt (cnt1)
`else
      .q_n        (qn1)
`endif
   );

   jk_flip_flop #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .j          (j4),
      .k          (k4),
      .q          (q4),
`ifdef JKFF_TOGGLE_CNT_EN
      .q_n        (qn4),
      .toggle_cnt (cnt4)
`else
      .q_n        (qn4)
`endif
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic drive(input logic r, input logic jj, input logic kk,
                        input logic [3:0] jv, input logic [3:0] kv);
      @(negedge clk);
      reset = r; j1 = jj; k1 = kk; j4 = jv; k4 = kv;
      @(posedge clk);
      #1;
   endtask

   // Pulse j/k high between edges, restore to hold before the next edge.
   task automatic glitch_hold();
      j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
      #3;
      j1 = 1'b0; k1 = 1'b0; j4 = 4'h0; k4 = 4'h0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus / scoreboard ----------------
   logic [1:0] tt_ops [5];

   initial begin
      // reset with j=k=1
      drive(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
      check("rst_q1",  q1,  32'h0);
      check("rst_qn1", qn1, 32'h1);
      check("rst_q4",  q4,  32'h0);
      check("rst_qn4", qn4, 32'hF);
`ifdef JKFF_TOGGLE_CNT_EN
      check("rst_cnt", cnt1, 32'h0);
`endif

      // truth table: set, reset, toggle, hold, toggle
      tt_ops[0] = 2'b10; tt_ops[1] = 2'b01; tt_ops[2] = 2'b11;
      tt_ops[3] = 2'b00; tt_ops[4] = 2'b11;
      exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
      exp_q.push_back(32'h1); exp_q.push_back(32'h0);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         drive(1'b0, tt_ops[i][1], tt_ops[i][0], 4'h0, 4'h0);
         check($sformatf("tt_q_%0d", i), q1, e);
         check($sformatf("tt_qn_%0d", i), qn1, {31'b0, ~e[0]});
      end

      // mid-sequence reset
      drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      check("mid_set", q1, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check("mid_rst_q",  q1,  32'h0);
      check("mid_rst_qn", qn1, 32'h1);
      drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
      check("mid_resume", q1, 32'h1);

      // multi-bit mixed operations
      drive(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000);
      check("mb_pre", q4, 32'h5);
      drive(1'b0, 1'b0, 1'b0, 4'b1100, 4'b1010);
      check("mb_q",  q4,  32'hD);
      check("mb_qn", qn4, 32'h2);

      // j/k activity between edges must be ignored
      glitch_hold();
      check("smp_q1", q1, 32'h1);
      check("smp_q4", q4, 32'hD);
      glitch_hold();
      check("smp2_q4", q4, 32'hD);

`ifdef JKFF_TOGGLE_CNT_EN
      drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      check("cnt_clr", cnt1, 32'h0);
      exp_q.push_back(32'h1); exp_q.push_back(32'h2); exp_q.push_back(32'h3);
      exp_q.push_back(32'h3); exp_q.push_back(32'h3);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
         check($sformatf("cnt_tg_%0d", i), cnt1, e);
         check($sformatf("cnt_q_%0d", i), q1, (i % 2 == 0) ? 32'h1 : 32'h0);
      end
      drive(1'b0, 1'b0, 1'b0, 4'h1, 4'h0);
      check("cnt_hold", cnt1, 32'h3);
      check("cnt4_one", cnt4, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
      check("cnt_rst",  cnt1, 32'h0);
      check("cnt_rstq", q1,   32'h0);
      check("cnt4_rst", cnt4, 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/jk_flip_flop.md
JK_FLIP_FLOP -- requirements
Module: jk_flip_flop

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent JK bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the toggle-event counter (used only with JKFF_TOGGLE_CNT_EN).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port j  input  WIDTH: per-bit J (set) input.
REQ-006 SHALL have port k  input  WIDTH: per-bit K (reset) input.
REQ-007 SHALL have port q  output  WIDTH: registered state.
REQ-008 SHALL have port q_n  output  WIDTH: bitwise complement of q, combinational from q.
REQ-009 SHALL have port toggle_cnt  output  CNT_W: count of edges on which q changed; present only with JKFF_TOGGLE_CNT_EN.

Function
REQ-010 SHALL update q only on the rising edge of clk; j and k are sampled on that edge.
REQ-011 SHALL apply per bit i, when reset=0: j=0,k=0 -> q[i] holds; j=0,k=1 -> q[i]=0; j=1,k=0 -> q[i]=1; j=1,k=1 -> q[i] toggles.
REQ-012 SHALL have a latency of one clock: the new q is visible after the sampling edge and stable until the next edge.
REQ-013 SHALL treat bits independently; mixed operations across bits in one cycle are legal.
REQ-014 SHALL ignore j/k changes between edges; there is no asynchronous path from j, k or reset to q.
REQ-015 SHALL keep q_n == ~q at all times, including during and after reset.
REQ-016 SHALL give reset priority over j/k: reset=1 at an edge forces q=0 regardless of j/k, including reset asserted mid-sequence.
REQ-017 SHALL resume normal JK operation on the first edge where reset=0, starting from q=0.

Reset
REQ-018 SHALL set q to all-zeros, q_n to all-ones, and toggle_cnt (if present) to 0 on a rising edge with reset=1.
REQ-019 SHALL NOT count a reset-induced change of q as a toggle event.
REQ-020 SHALL leave q undefined before the first reset edge; benches must reset first.

Configuration
REQ-021 SHALL honour the macro JKFF_TOGGLE_CNT_EN.
- Defined: toggle_cnt exists. It increments by 1 on each non-reset edge where the next q differs from the current q in any bit. It saturates at 2^CNT_W-1 and never wraps.
- Undefined: no toggle_cnt port and no counter logic. q/q_n behaviour is identical in both builds.

Structure
REQ-022 SHALL place in shared package jkff_pkg:
- enum jk_op_t {JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11}, encoded as {j,k}.
- constant JKFF_RESET_VAL = 1'b0.
REQ-023 SHALL implement the next-state rule in a sub-module jk_bit_cell (one bit, combinational next-state plus register), generated WIDTH times. The counter lives in the top level.

Verification
REQ-024 Reset: WIDTH=1, reset=1 for one edge with j=1,k=1 -> q=0, q_n=1, toggle_cnt=0.
REQ-025 Truth table: after reset, drive one op per edge: set (1,0) -> 1; reset (0,1) -> 0; toggle (1,1) -> 1; hold (0,0) -> 1; toggle (1,1) -> 0.
REQ-026 Mid-sequence reset: from q=1, reset=1 with j=1,k=0 -> q=0. Next edge, reset=0, j=1,k=0 -> q=1.
REQ-027 Multi-bit: WIDTH=4, q=4'b0101, j=4'b1100, k=4'b1010 -> q=4'b1101, q_n=4'b0010.
REQ-028 Counter (macro defined, CNT_W=2): five consecutive toggles from q=0 -> toggle_cnt=1,2,3,3,3; a hold edge leaves it unchanged; reset clears it to 0.
REQ-029 Sampling: change j/k between edges, restoring them before the next edge -> q unchanged; build without the macro compiles with no toggle_cnt port.
